fast_arc_scorer: RTL and testbench
==================================

Name: fast_arc_scorer

Overview:
- Consumer stage directly downstream of the FAST ring thresholder in the corner-detection pipeline.
- Accepts the registered 16-bit bright/dark masks and the thresholded ring differences.
- Decides whether a contiguous arc of ARC_LEN qualifying ring pixels exists; wrap-around of the 16-pixel ring counts as contiguous.
- Emits a corner flag, a corner score for later non-max suppression, and a per-frame corner count.

Parameters:
- PIXEL_WIDTH, 8, pixel bit width. Difference width DW = PIXEL_WIDTH+2.
- ARC_LEN, 9, minimum contiguous ring length for a corner. Legal range 1..16.
- CNT_WIDTH, 16, width of the per-frame corner counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-low.
- ce  in  1  clock enable; the pipeline advances only when ce=1.
- in_vld  in  1  the current mask/difference set is a valid 7x7 patch.
- sof  in  1  start-of-frame pulse, sampled only when ce=1.
- bright  in  16  bit i set: ring pixel i is brighter than center+threshold.
- dark  in  16  bit i set: ring pixel i is darker than center-threshold.
- diff_b  in  16*DW  packed; slice i = bright difference for ring pixel i; 0 when the bright bit is clear.
- diff_d  in  16*DW  packed dark differences, same layout as diff_b.
- out_vld  out  1  is_corner/score are valid for a patch.
- is_corner  out  1  an arc of at least ARC_LEN exists.
- score  out  DW+4  corner score.
- corner_cnt  out  CNT_WIDTH  corners counted since the last sof.

Behaviour:
- Reset: rst=0 at a clk edge clears all pipeline registers and all outputs to 0 (out_vld, is_corner, score, corner_cnt). Reset wins over ce.
- Reset mid-operation: in-flight patches are discarded. No out_vld is produced for them.
- Stall: when ce=0, every register holds, including outputs and the counter. Output flags are not re-pulsed.
- Latency: exactly 3 ce-qualified cycles from in_vld to out_vld. in_vld travels down a 3-deep valid shift chain.
- Stage 1:
  - arc_b = OR over start index s=0..15 of AND over k=0..ARC_LEN-1 of bright[(s+k) mod 16]. arc_d is the same function of dark.
  - Compute 4 partial sums per polarity, each over 4 consecutive slices, width DW+2.
- Stage 2:
  - sum_b and sum_d, width DW+4, unsigned; overflow is impossible.
  - arc flags and valid are delayed alongside.
- Stage 3 score selection:
  - arc_b only: score = sum_b.
  - arc_d only: score = sum_d.
  - Both: score = max(sum_b, sum_d); ties take sum_b.
  - Neither: score = 0.
- Stage 3 flags: is_corner = valid & (arc_b | arc_d). out_vld = valid. When valid=0, is_corner=0 and score=0.
- Counter:
  - On a ce cycle with sof=1, corner_cnt clears to 0. A corner completing in that same cycle is then counted, so the count becomes 1.
  - Otherwise, each cycle with is_corner_next=1 increments corner_cnt.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
- Masks are used as given. Inputs with both bright and dark bits set are not rejected; arc detection on each polarity is independent.

Optional Feature:
- Macro: FAST_SCORE_EN.
- Defined: score is computed as above.
- Undefined:
  - The adder tree and diff_b/diff_d registers are removed, and diff_b/diff_d are left unused.
  - score is tied to 0.
  - Latency, out_vld and is_corner timing are unchanged; arc flags still pass through 3 stages.

Decomposition:
- Package fast_pkg holds:
  - localparams RING_SIZE=16 and DW.
  - typedef diff_t (logic [DW-1:0]).
  - typedef score_t (logic [DW+3:0]).
  - function arc_detect(mask, len), shared with the testbench model.
- One sub-module, fast_sum16: a pipelined 2-level adder tree of 16 diff_t values, instantiated per polarity.

Test Plan:
- Arc hit: bright=16'h01FF, diff_b slices 0..8=5, others 0, in_vld=1, ce=1 -> 3 cycles later out_vld=1, is_corner=1, score=45.
- Wrap-around and short arc: bright=16'hF01F (bits 12..15 and 0..4, 9 bits) -> is_corner=1. bright=16'h00FF (8 bits) -> is_corner=0, score=0, out_vld=1.
- Maximum score: dark=16'hFFFF, all diff_d=245 -> is_corner=1, score=3920.
- Stall: insert ce=0 for 4 cycles mid-stream -> outputs frozen, out_vld appears after 3 ce=1 cycles, no duplicate pulse.
- Counter:
  - 5 corner patches, then sof -> corner_cnt=5, then 0.
  - sof coinciding with a completing corner -> corner_cnt=1.
  - With CNT_WIDTH=2, 6 corners -> corner_cnt holds at 3.
- Reset mid-flight: rst=0 for 1 cycle while 2 patches are in flight -> all outputs 0 and no out_vld for the discarded patches. Without FAST_SCORE_EN, repeat the first scenario -> score=0, is_corner=1.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared types and the ring arc detector for the FAST corner scorer.
package fast_pkg;

    localparam int unsigned RING_SIZE   = 16;
    localparam int unsigned PIXEL_WIDTH = 8;
    localparam int unsigned DW          = PIXEL_WIDTH + 2;

    typedef logic [DW-1:0] diff_t;
    typedef logic [DW+3:0] score_t;

    // True when `len` consecutive mask bits are set, wrapping around the ring.
    function automatic logic arc_detect(input logic [RING_SIZE-1:0] mask,
                                        input int unsigned          len);
        logic hit;
        logic run;
        hit = 1'b0;
        for (int unsigned s = 0; s < RING_SIZE; s++) begin
            run = 1'b1;
            for (int unsigned k = 0; k < RING_SIZE; k++) begin
                if (k < len) begin
                    run = run & mask[4'(s + k)];
                end
            end
            hit = hit | run;
        end
        return hit;
    endfunction

endpackage

// File: rtl/fast_sum16.sv
// Two-level pipelined adder tree summing the 16 ring differences of one polarity.
module fast_sum16
    import fast_pkg::*;
#(
    parameter int unsigned W = DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic [RING_SIZE*W-1:0]   din_i,
    output logic [W+3:0]             sum_o
);

    localparam int unsigned PW = W + 2;
    localparam int unsigned SW = W + 4;

    logic [PW-1:0] part_d [4];
    logic [PW-1:0] part_q [4];
    logic [SW-1:0] sum_d;
    logic [SW-1:0] sum_q;

    // Level 1 forms four quad sums, level 2 adds the registered quads.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            part_d[g] = '0;
            for (int j = 0; j < 4; j++) begin
                part_d[g] = part_d[g] + PW'(din_i[(4*g+j)*W +: W]);
            end
        end
        sum_d = SW'(part_q[0]) + SW'(part_q[1]) + SW'(part_q[2]) + SW'(part_q[3]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            part_q <= '{default: '0};
            sum_q  <= '0;
        end else if (ce) begin
            part_q <= part_d;
            sum_q  <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/fast_arc_scorer.sv
// FAST arc test, corner score and per-frame corner count (3-cycle pipeline).
// Define FAST_SCORE_EN to build the difference adder trees; otherwise score is 0.
module fast_arc_scorer
    import fast_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = fast_pkg::PIXEL_WIDTH,
    parameter int unsigned ARC_LEN     = 9,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ce,
    input  logic                              in_vld,
    input  logic                              sof,
    input  logic [RING_SIZE-1:0]              bright,
    input  logic [RING_SIZE-1:0]              dark,
    input  logic [RING_SIZE*(PIXEL_WIDTH+2)-1:0] diff_b,
    input  logic [RING_SIZE*(PIXEL_WIDTH+2)-1:0] diff_d,
    output logic                              out_vld,
    output logic                              is_corner,
    output logic [PIXEL_WIDTH+5:0]            score,
    output logic [CNT_WIDTH-1:0]              corner_cnt
);

    localparam int unsigned DWL = PIXEL_WIDTH + 2;
    localparam int unsigned SW  = DWL + 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 v1_q, ab1_q, ad1_q;
    logic                 v2_q, ab2_q, ad2_q;
    logic [SW-1:0]        sum_b2, sum_d2;
    logic                 out_vld_q, is_corner_q;
    logic [SW-1:0]        score_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 corner_d;
    logic [SW-1:0]        score_d;
    logic [CNT_WIDTH-1:0] cnt_d;

`ifdef FAST_SCORE_EN
    fast_sum16 #(.W(DWL)) u_sum_b (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .din_i (diff_b),
        .sum_o (sum_b2)
    );

    fast_sum16 #(.W(DWL)) u_sum_d (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .din_i (diff_d),
        .sum_o (sum_d2)
    );
`else
    logic unused_diff;
    assign unused_diff = ^{diff_b, diff_d};
    assign sum_b2      = '0;
    assign sum_d2      = '0;
`endif

    // Arc flags and valid ride alongside the adder tree for two stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q  <= 1'b0;
            ab1_q <= 1'b0;
            ad1_q <= 1'b0;
            v2_q  <= 1'b0;
            ab2_q <= 1'b0;
            ad2_q <= 1'b0;
        end else if (ce) begin
            v1_q  <= in_vld;
            ab1_q <= arc_detect(bright, ARC_LEN);
            ad1_q <= arc_detect(dark, ARC_LEN);
            v2_q  <= v1_q;
            ab2_q <= ab1_q;
            ad2_q <= ad1_q;
        end
    end

    // Score select (ties favour bright) and saturating frame counter.
    always_comb begin
        corner_d = v2_q & (ab2_q | ad2_q);
        score_d  = '0;
        cnt_d    = cnt_q;
        if (v2_q) begin
            if (ab2_q && ad2_q) begin
                score_d = (sum_d2 > sum_b2) ? sum_d2 : sum_b2;
            end else if (ab2_q) begin
                score_d = sum_b2;
            end else if (ad2_q) begin
                score_d = sum_d2;
            end
        end
        if (sof) begin
            cnt_d = corner_d ? CNT_WIDTH'(1) : '0;
        end else if (corner_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld_q   <= 1'b0;
            is_corner_q <= 1'b0;
            score_q     <= '0;
            cnt_q       <= '0;
        end else if (ce) begin
            out_vld_q   <= v2_q;
            is_corner_q <= corner_d;
            score_q     <= score_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_vld    = out_vld_q;
    assign is_corner  = is_corner_q;
    assign score      = score_q;
    assign corner_cnt = cnt_q;

endmodule

// File: tb/tb_fast_arc_scorer.sv
// Directed bench for fast_arc_scorer: vector table plus counter, stall and reset sequences.
module tb_fast_arc_scorer;
    import fast_pkg::*;

    localparam int unsigned N = 11;
`ifdef FAST_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst, ce, in_vld, sof;
    logic [15:0]              bright, dark;
    logic [16*DW-1:0]         diff_b, diff_d;
    logic                     out_vld, is_corner, out_vld2, is_corner2;
    score_t                   score, score2;
    logic [15:0]              corner_cnt;
    logic [1:0]               corner_cnt2;

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    typedef struct {
        logic [15:0] b;
        logic [15:0] d;
        int          vb;
        int          vd;
        bit          corner;
        int          sc;
    } vec_t;
    vec_t tbl [N];

    always #5 clk = ~clk;

    fast_arc_scorer dut (
        .clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld), .sof(sof),
        .bright(bright), .dark(dark), .diff_b(diff_b), .diff_d(diff_d),
        .out_vld(out_vld), .is_corner(is_corner), .score(score),
        .corner_cnt(corner_cnt)
    );

    fast_arc_scorer #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld), .sof(sof),
        .bright(bright), .dark(dark), .diff_b(diff_b), .diff_d(diff_d),
        .out_vld(out_vld2), .is_corner(is_corner2), .score(score2),
        .corner_cnt(corner_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [16*DW-1:0] pack(input logic [15:0] m, input int v);
        logic [16*DW-1:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*DW +: DW] = m[i] ? DW'(v) : '0;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [15:0] b, input logic [15:0] d,
                         input int vb, input int vd, input logic s, input logic c);
        in_vld = v;
        bright = b;
        dark   = d;
        diff_b = pack(b, vb);
        diff_d = pack(d, vd);
        sof    = s;
        ce     = c;
    endtask

    task automatic idle(input logic s);
        drive(1'b0, 16'h0000, 16'h0000, 0, 0, s, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int esc(input int s);
        return SCORE_EN ? s : 0;
    endfunction

    initial begin
        tbl[0]  = '{16'h01FF, 16'h0000, 5,   0,   1'b1, 45};
        tbl[1]  = '{16'hF01F, 16'h0000, 3,   0,   1'b1, 27};
        tbl[2]  = '{16'h00FF, 16'h0000, 7,   0,   1'b0, 0};
        tbl[3]  = '{16'h0000, 16'hFFFF, 0,   245, 1'b1, 3920};
        tbl[4]  = '{16'h01FF, 16'hFF80, 10,  20,  1'b1, 180};
        tbl[5]  = '{16'h01FF, 16'hFF80, 4,   4,   1'b1, 36};
        tbl[6]  = '{16'h0000, 16'h7FC0, 0,   1,   1'b1, 9};
        tbl[7]  = '{16'hAAAA, 16'h0000, 9,   0,   1'b0, 0};
        tbl[8]  = '{16'hFFFF, 16'h0000, 0,   0,   1'b1, 0};
        tbl[9]  = '{16'h3FE0, 16'h00F0, 245, 100, 1'b1, 2205};
        tbl[10] = '{16'h8000, 16'h0001, 50,  50,  1'b0, 0};

        // Reset with ce low: reset must still win.
        rst = 1'b0;
        drive(1'b1, 16'hFFFF, 16'hFFFF, 3, 3, 1'b0, 1'b0);
        tick();
        tick();
        check("rst out_vld", 32'(out_vld), 0);
        check("rst is_corner", 32'(is_corner), 0);
        check("rst score", 32'(score), 0);
        check("rst cnt", 32'(corner_cnt), 0);
        rst = 1'b1;
        idle(1'b1);
        tick();

        // Streamed table: output of vector c-2 is visible after edge c.
        exp_cnt = 0;
        for (int c = 0; c < N + 2; c++) begin
            if (c < N) drive(1'b1, tbl[c].b, tbl[c].d, tbl[c].vb, tbl[c].vd, 1'b0, 1'b1);
            else idle(1'b0);
            tick();
            if (c < 2) begin
                check($sformatf("fill%0d out_vld", c), 32'(out_vld), 0);
            end else begin
                exp_cnt += int'(tbl[c-2].corner);
                check($sformatf("vec%0d out_vld", c-2), 32'(out_vld), 1);
                check($sformatf("vec%0d corner", c-2), 32'(is_corner), 32'(tbl[c-2].corner));
                check($sformatf("vec%0d score", c-2), 32'(score), 32'(esc(tbl[c-2].sc)));
                check($sformatf("vec%0d cnt", c-2), 32'(corner_cnt), 32'(exp_cnt));
                check($sformatf("vec%0d cnt2", c-2), 32'(corner_cnt2), 32'((exp_cnt > 3) ? 3 : exp_cnt));
            end
        end
        idle(1'b0);
        tick();
        check("drain out_vld", 32'(out_vld), 0);

        // Frame boundary clears the count, then five corners.
        idle(1'b1);
        tick();
        check("sof clear cnt", 32'(corner_cnt), 0);
        check("sof clear cnt2", 32'(corner_cnt2), 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, tbl[0].b, tbl[0].d, tbl[0].vb, tbl[0].vd, 1'b0, 1'b1);
            tick();
        end
        idle(1'b0);
        tick();
        tick();
        check("five cnt", 32'(corner_cnt), 5);
        check("sat cnt2", 32'(corner_cnt2), 3);
        idle(1'b1);
        tick();
        check("five then sof", 32'(corner_cnt), 0);

        // sof on the same edge a corner completes counts that corner.
        drive(1'b1, tbl[0].b, tbl[0].d, tbl[0].vb, tbl[0].vd, 1'b0, 1'b1);
        tick();
        drive(1'b1, tbl[1].b, tbl[1].d, tbl[1].vb, tbl[1].vd, 1'b0, 1'b1);
        tick();
        idle(1'b0);
        tick();
        check("pre-sof cnt", 32'(corner_cnt), 1);
        idle(1'b1);
        tick();
        check("sof+corner cnt", 32'(corner_cnt), 1);
        check("sof+corner flag", 32'(is_corner), 1);
        check("sof+corner cnt2", 32'(corner_cnt2), 1);

        // Stall: garbage while ce=0 must be ignored, outputs frozen.
        drive(1'b1, tbl[1].b, tbl[1].d, tbl[1].vb, tbl[1].vd, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hFFFF, 16'hFFFF, 7, 7, 1'b0, 1'b0);
            tick();
            check($sformatf("stall%0d out_vld", i), 32'(out_vld), 0);
            check($sformatf("stall%0d cnt", i), 32'(corner_cnt), 1);
        end
        idle(1'b0);
        tick();
        check("post-stall 2nd ce vld", 32'(out_vld), 0);
        tick();
        check("post-stall out_vld", 32'(out_vld), 1);
        check("post-stall corner", 32'(is_corner), 1);
        check("post-stall score", 32'(score), 32'(esc(27)));
        check("post-stall cnt", 32'(corner_cnt), 2);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hFFFF, 16'hFFFF, 7, 7, 1'b1, 1'b0);
            tick();
            check($sformatf("hold%0d out_vld", i), 32'(out_vld), 1);
            check($sformatf("hold%0d score", i), 32'(score), 32'(esc(27)));
            check($sformatf("hold%0d cnt", i), 32'(corner_cnt), 2);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            tick();
            check($sformatf("no repulse%0d", i), 32'(out_vld), 0);
        end
        check("after stall cnt", 32'(corner_cnt), 2);

        // Reset with two patches in flight discards them.
        drive(1'b1, tbl[0].b, tbl[0].d, tbl[0].vb, tbl[0].vd, 1'b0, 1'b1);
        tick();
        drive(1'b1, tbl[3].b, tbl[3].d, tbl[3].vb, tbl[3].vd, 1'b0, 1'b1);
        tick();
        idle(1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst out_vld", 32'(out_vld), 0);
        check("midrst corner", 32'(is_corner), 0);
        check("midrst score", 32'(score), 0);
        check("midrst cnt", 32'(corner_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst drain%0d", i), 32'(out_vld), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
